if_stage_pc: RTL and testbench
==============================

// Module: if_stage_pc
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, PC+4 incrementer, next-PC select and IF/ID register.
//  Consumes the branch target produced by the EX-stage branch adder (PC+4 + sign-extended offset) and the jump target.
//  Feeds the ID stage with {PC+4, instruction, valid}; PC+4 here is the operand the branch adder later uses.
//  Small control FSM handles halt; flush and stall come from the hazard unit.
// PARAMETERS
//  PC_W      10            PC/address width in bits (byte address, word aligned)
//  INSTR_W   32            instruction width
//  RESET_PC  0             PC value loaded on reset
//  HALT_WORD 32'hFFFF_FFFF instruction encoding that stops fetch
// PORTS
//  clk              in   1        rising-edge clock
//  reset            in   1        synchronous, active-high
//  stall_i          in   1        hazard unit: hold PC and IF/ID
//  branch_taken_i   in   1        EX stage: branch resolved taken
//  branch_target_i  in   PC_W     EX stage: branch adder result
//  jump_i           in   1        ID stage: jump decoded
//  jump_target_i    in   PC_W     ID stage: jump target
//  imem_addr_o      out  PC_W     instruction memory address (= PC)
//  imem_rdata_i     in   INSTR_W  instruction memory data, combinational read of imem_addr_o
//  if_id_pc4_o      out  PC_W     IF/ID: PC+4 of fetched instruction
//  if_id_instr_o    out  INSTR_W  IF/ID: fetched instruction
//  if_id_valid_o    out  1        IF/ID: 1 = real instruction, 0 = bubble
//  halt_o           out  1        fetch halted
//  fetch_count_o    out  16       count of instructions delivered to IF/ID, saturating
// BEHAVIOUR
//  Reset (sync, highest priority): pc=RESET_PC, if_id_pc4=0, if_id_instr=0, if_id_valid=0, halt_o=0, fetch_count=0, state=RUN.
//  Combinational: imem_addr_o=pc; pc4=pc+4 truncated to PC_W (wraps 2^PC_W-4 -> 0).
//  Redirect = branch_taken_i | jump_i. Branch wins over jump when both are set (branch is the older instruction).
//  Redirect target = {target[PC_W-1:2],2'b00}: low two bits are forced to zero, no exception.
//  FSM states: RUN, HALT.
//  RUN, per clock edge, in priority order:
//   1. redirect:
//      - pc <= aligned target.
//      - IF/ID flushed: valid=0, instr=0, pc4=0.
//      - Overrides stall_i.
//   2. stall_i: pc, IF/ID and count all hold.
//   3. imem_rdata_i==HALT_WORD:
//      - pc holds.
//      - IF/ID loads bubble (valid=0, instr=0, pc4=0).
//      - state <= HALT; halt_o=1 from the next cycle.
//   4. otherwise:
//      - pc <= pc4.
//      - IF/ID <= {pc4, imem_rdata_i, 1}.
//      - fetch_count += 1, saturating at 16'hFFFF.
//  HALT:
//   - pc, count and halt_o=1 hold; IF/ID holds the bubble.
//   - stall_i and redirects are ignored.
//   - Only reset leaves HALT.
//  Latency: instruction at PC appears on if_id_* one cycle after PC is presented. Redirect costs one bubble cycle in IF/ID.
//  Reset asserted mid-stall or mid-redirect: reset wins on that edge, with no partial update.
// STRUCTURE
//  Shared package (mips_pkg):
//   - PC_W, INSTR_W, NOP_INSTR = 32'h0, HALT_WORD.
//   - if_state_t enum {RUN, HALT}.
//  Sub-module pc_next_sel: combinational redirect priority, target alignment and pc4.
//  The top module holds the FSM, PC register, IF/ID register and counter.
// TESTING
//  1. Reset, imem returns i+1 at addr i, no stalls.
//     -> pc 0,4,8 on successive cycles; if_id_pc4=4, valid=1 after the first edge; count=3 after three edges.
//  2. At pc=0x08, branch_taken_i=1, target=0x40, stall_i=1 in the same cycle.
//     -> next pc=0x40; if_id_valid=0 and instr=0 for one cycle; count unchanged.
//  3. stall_i held for 3 cycles at pc=0x0C.
//     -> pc=0x0C and IF/ID unchanged for all 3 cycles; normal fetch resumes on the 4th edge.
//  4. Jump to 0x3FC.
//     -> fetch at 0x3FC gives if_id_pc4=0x000, next pc=0x000 (wrap).
//  5. branch_taken_i=1 (target 0x43) and jump_i=1 (target 0x80) in the same cycle.
//     -> pc=0x40.
//  6. HALT_WORD at 0x10.
//     -> halt_o=1 next cycle; pc stays 0x10; a later branch to 0x40 is ignored.
//     -> Asserting reset returns pc=0, halt_o=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: widths, special
// instruction encodings and the fetch control state type.
package mips_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } if_state_t;

endpackage

// File: rtl/if_stage_pc_if.sv
// Instruction memory bus between the fetch stage (master) and the
// instruction memory (slave); the read is combinational on the address.
interface if_stage_pc_if;
    import mips_pkg::*;

    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC helper: sequential PC+4 and the redirect target, with the
// branch taking priority over the jump because it is the older instruction.
module pc_next_sel
    import mips_pkg::*;
(
    input  logic [PC_W-1:0] pc_i,
    input  logic            branch_taken_i,
    input  logic [PC_W-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [PC_W-1:0] jump_target_i,
    output logic            redirect_o,
    output logic [PC_W-1:0] target_o,
    output logic [PC_W-1:0] pc4_o
);

    always_comb begin
        redirect_o = branch_taken_i | jump_i;
        // Misaligned targets are silently forced onto a word boundary.
        if (branch_taken_i) begin
            target_o = {branch_target_i[PC_W-1:2], 2'b00};
        end else begin
            target_o = {jump_target_i[PC_W-1:2], 2'b00};
        end
        pc4_o = pc_i + PC_W'(4);
    end

endmodule

// File: rtl/if_stage_pc.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, delivered
// instruction counter and the RUN/HALT control FSM.
module if_stage_pc
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [PC_W-1:0]    branch_target_i,
    input  logic               jump_i,
    input  logic [PC_W-1:0]    jump_target_i,
    if_stage_pc_if.master      imem,
    output logic [PC_W-1:0]    if_id_pc4_o,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic               if_id_valid_o,
    output logic               halt_o,
    output logic [CNT_W-1:0]   fetch_count_o
);

    if_state_t          state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pc4_q, pc4_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               redirect;
    logic [PC_W-1:0]    target;
    logic [PC_W-1:0]    pc4;

    pc_next_sel u_pc_next_sel (
        .pc_i            (pc_q),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .redirect_o      (redirect),
        .target_o        (target),
        .pc4_o           (pc4)
    );

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // if/else chain leaves it unassigned, which would infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        count_d = count_q;

        if (state_q == RUN) begin
            if (redirect) begin
                pc_d    = target;
                pc4_d   = '0;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end else if (stall_i) begin
                pc_d = pc_q;
            end else if (imem.imem_rdata == HALT_WORD) begin
                pc4_d   = '0;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                state_d = HALT;
            end else begin
                pc_d    = pc4;
                pc4_d   = pc4;
                instr_d = imem.imem_rdata;
                valid_d = 1'b1;
                if (count_q != '1) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            pc4_q   <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign if_id_pc4_o    = pc4_q;
    assign if_id_instr_o  = instr_q;
    assign if_id_valid_o  = valid_q;
    assign halt_o         = (state_q == HALT);
    assign fetch_count_o  = count_q;

endmodule

// File: tb/tb_if_stage_pc.sv
// Directed bench for if_stage_pc: instruction memory returns addr+1, with an
// optional halt word planted at 0x10.
module tb_if_stage_pc;
    import mips_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               stall_i;
    logic               branch_taken_i;
    logic [PC_W-1:0]    branch_target_i;
    logic               jump_i;
    logic [PC_W-1:0]    jump_target_i;
    logic [PC_W-1:0]    if_id_pc4_o;
    logic [INSTR_W-1:0] if_id_instr_o;
    logic               if_id_valid_o;
    logic               halt_o;
    logic [CNT_W-1:0]   fetch_count_o;
    logic               halt_en;

    int n_pass  = 0;
    int n_total = 0;

    if_stage_pc_if imem_bus ();

    assign imem_bus.imem_rdata = (halt_en && imem_bus.imem_addr == 10'h010) ? 32'hFFFF_FFFF
                                 : {22'd0, imem_bus.imem_addr} + 32'd1;

    if_stage_pc dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .imem            (imem_bus.master),
        .if_id_pc4_o     (if_id_pc4_o),
        .if_id_instr_o   (if_id_instr_o),
        .if_id_valid_o   (if_id_valid_o),
        .halt_o          (halt_o),
        .fetch_count_o   (fetch_count_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset           = 1'b1;
        stall_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = '0;
        jump_i          = 1'b0;
        jump_target_i   = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        halt_en = 1'b0;
        apply_reset();
        n_total++;
        if (imem_bus.imem_addr !== 10'h000 || if_id_valid_o !== 1'b0 || halt_o !== 1'b0 ||
            fetch_count_o !== 16'h0 || if_id_pc4_o !== 10'h000 || if_id_instr_o !== 32'h0)
            $display("FAIL reset: pc=%h valid=%b halt=%b cnt=%h pc4=%h instr=%h, want 000/0/0/0000/000/0",
                     imem_bus.imem_addr, if_id_valid_o, halt_o, fetch_count_o, if_id_pc4_o, if_id_instr_o);
        else n_pass++;
    endtask

    task automatic test_sequential();
        logic [PC_W-1:0]    exp_pc  [3] = '{10'h004, 10'h008, 10'h00C};
        logic [INSTR_W-1:0] exp_ins [3] = '{32'h1, 32'h5, 32'h9};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (imem_bus.imem_addr !== exp_pc[i] || if_id_pc4_o !== exp_pc[i] ||
                if_id_instr_o !== exp_ins[i] || if_id_valid_o !== 1'b1 ||
                fetch_count_o !== 16'(i + 1))
                $display("FAIL seq[%0d]: pc=%h pc4=%h instr=%h valid=%b cnt=%0d, want pc=pc4=%h instr=%h valid=1 cnt=%0d",
                         i, imem_bus.imem_addr, if_id_pc4_o, if_id_instr_o, if_id_valid_o,
                         fetch_count_o, exp_pc[i], exp_ins[i], i + 1);
            else n_pass++;
        end
    endtask

    task automatic test_branch_over_stall();
        apply_reset();
        step();
        step();
        branch_taken_i  = 1'b1;
        branch_target_i = 10'h040;
        stall_i         = 1'b1;
        step();
        branch_taken_i = 1'b0;
        stall_i        = 1'b0;
        n_total++;
        if (imem_bus.imem_addr !== 10'h040 || if_id_valid_o !== 1'b0 ||
            if_id_instr_o !== 32'h0 || if_id_pc4_o !== 10'h000 || fetch_count_o !== 16'd2)
            $display("FAIL branch_flush: pc=%h valid=%b instr=%h pc4=%h cnt=%0d, want 040/0/0/000/2",
                     imem_bus.imem_addr, if_id_valid_o, if_id_instr_o, if_id_pc4_o, fetch_count_o);
        else n_pass++;
        step();
        n_total++;
        if (imem_bus.imem_addr !== 10'h044 || if_id_valid_o !== 1'b1 ||
            if_id_instr_o !== 32'h41 || if_id_pc4_o !== 10'h044 || fetch_count_o !== 16'd3)
            $display("FAIL branch_resume: pc=%h valid=%b instr=%h pc4=%h cnt=%0d, want 044/1/41/044/3",
                     imem_bus.imem_addr, if_id_valid_o, if_id_instr_o, if_id_pc4_o, fetch_count_o);
        else n_pass++;
    endtask

    task automatic test_stall();
        apply_reset();
        repeat (3) step();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (imem_bus.imem_addr !== 10'h00C || if_id_pc4_o !== 10'h00C ||
                if_id_instr_o !== 32'h9 || if_id_valid_o !== 1'b1 || fetch_count_o !== 16'd3)
                $display("FAIL stall[%0d]: pc=%h pc4=%h instr=%h valid=%b cnt=%0d, want 00C/00C/9/1/3",
                         i, imem_bus.imem_addr, if_id_pc4_o, if_id_instr_o, if_id_valid_o, fetch_count_o);
            else n_pass++;
        end
        stall_i = 1'b0;
        step();
        n_total++;
        if (imem_bus.imem_addr !== 10'h010 || if_id_pc4_o !== 10'h010 ||
            if_id_instr_o !== 32'hD || fetch_count_o !== 16'd4)
            $display("FAIL stall_resume: pc=%h pc4=%h instr=%h cnt=%0d, want 010/010/D/4",
                     imem_bus.imem_addr, if_id_pc4_o, if_id_instr_o, fetch_count_o);
        else n_pass++;
    endtask

    task automatic test_jump_wrap();
        apply_reset();
        jump_i        = 1'b1;
        jump_target_i = 10'h3FC;
        step();
        jump_i = 1'b0;
        n_total++;
        if (imem_bus.imem_addr !== 10'h3FC || if_id_valid_o !== 1'b0)
            $display("FAIL jump: pc=%h valid=%b, want 3FC/0", imem_bus.imem_addr, if_id_valid_o);
        else n_pass++;
        step();
        n_total++;
        if (imem_bus.imem_addr !== 10'h000 || if_id_pc4_o !== 10'h000 ||
            if_id_instr_o !== 32'h3FD || if_id_valid_o !== 1'b1)
            $display("FAIL wrap: pc=%h pc4=%h instr=%h valid=%b, want 000/000/3FD/1",
                     imem_bus.imem_addr, if_id_pc4_o, if_id_instr_o, if_id_valid_o);
        else n_pass++;
    endtask

    task automatic test_branch_vs_jump();
        apply_reset();
        branch_taken_i  = 1'b1;
        branch_target_i = 10'h043;
        jump_i          = 1'b1;
        jump_target_i   = 10'h080;
        step();
        branch_taken_i = 1'b0;
        jump_i         = 1'b0;
        n_total++;
        if (imem_bus.imem_addr !== 10'h040)
            $display("FAIL branch_prio: pc=%h, want 040", imem_bus.imem_addr);
        else n_pass++;
    endtask

    task automatic test_halt();
        apply_reset();
        halt_en = 1'b1;
        repeat (4) step();
        n_total++;
        if (imem_bus.imem_addr !== 10'h010 || halt_o !== 1'b0 || fetch_count_o !== 16'd4)
            $display("FAIL pre_halt: pc=%h halt=%b cnt=%0d, want 010/0/4",
                     imem_bus.imem_addr, halt_o, fetch_count_o);
        else n_pass++;
        step();
        n_total++;
        if (imem_bus.imem_addr !== 10'h010 || halt_o !== 1'b1 || if_id_valid_o !== 1'b0 ||
            if_id_instr_o !== 32'h0 || fetch_count_o !== 16'd4)
            $display("FAIL halt: pc=%h halt=%b valid=%b instr=%h cnt=%0d, want 010/1/0/0/4",
                     imem_bus.imem_addr, halt_o, if_id_valid_o, if_id_instr_o, fetch_count_o);
        else n_pass++;
        branch_taken_i  = 1'b1;
        branch_target_i = 10'h040;
        repeat (2) step();
        n_total++;
        if (imem_bus.imem_addr !== 10'h010 || halt_o !== 1'b1)
            $display("FAIL halt_ignore_branch: pc=%h halt=%b, want 010/1", imem_bus.imem_addr, halt_o);
        else n_pass++;
        // Reset while a redirect and a stall are both pending.
        stall_i = 1'b1;
        reset   = 1'b1;
        step();
        reset          = 1'b0;
        stall_i        = 1'b0;
        branch_taken_i = 1'b0;
        halt_en        = 1'b0;
        n_total++;
        if (imem_bus.imem_addr !== 10'h000 || halt_o !== 1'b0 || fetch_count_o !== 16'd0)
            $display("FAIL halt_reset: pc=%h halt=%b cnt=%0d, want 000/0/0",
                     imem_bus.imem_addr, halt_o, fetch_count_o);
        else n_pass++;
    endtask

    task automatic test_count_saturate();
        apply_reset();
        repeat (65540) step();
        n_total++;
        if (fetch_count_o !== 16'hFFFF)
            $display("FAIL count_sat: cnt=%h, want FFFF", fetch_count_o);
        else n_pass++;
    endtask

    initial begin
        halt_en = 1'b0;
        test_reset();
        test_sequential();
        test_branch_over_stall();
        test_stall();
        test_jump_wrap();
        test_branch_vs_jump();
        test_halt();
        test_count_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
